// File: rtl/blob_list_writer.sv
// Writes accepted blob records as 3-word RAM entries, then a 3-word 0xFFFFFFFF terminator.
// Optional size filter: define BLOB_SIZE_FILTER_EN to drop blobs smaller than minimum_blob_size.
module blob_list_writer #(
  parameter int unsigned BASE_ADDR = 200000,
  parameter int unsigned MAX_BLOBS = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_blob_writer,
  input  logic        pause,
  input  logic [7:0]  minimum_blob_size,
  input  logic        blob_valid,
  input  logic [15:0] blob_size,
  input  logic [31:0] blob_word0,
  input  logic [31:0] blob_word1,
  input  logic [31:0] blob_word2,
  input  logic        extraction_done,
  output logic        blob_ready,
  output logic        wren,
  output logic [17:0] address,
  output logic [31:0] data_write,
  output logic [15:0] blob_extraction_blob_counter,
  output logic        blob_list_overflow,
  output logic        blob_list_done
);

  localparam logic [17:0] BASE = 18'(BASE_ADDR);
  localparam logic [15:0] CAP  = 16'(MAX_BLOBS);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] WAIT_BLOB = 4'd1;
  localparam logic [3:0] WR0       = 4'd2;
  localparam logic [3:0] WR1       = 4'd3;
  localparam logic [3:0] WR2       = 4'd4;
  localparam logic [3:0] TERM0     = 4'd5;
  localparam logic [3:0] TERM1     = 4'd6;
  localparam logic [3:0] TERM2     = 4'd7;
  localparam logic [3:0] DONE      = 4'd8;

  logic [3:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        dflag_q, dflag_d;
  // Tracks BASE + 3*counter so no multiplier is needed for the entry address.
  logic [17:0] entry_q, entry_d;
  logic [31:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic        size_drop;

`ifdef BLOB_SIZE_FILTER_EN
  assign size_drop = blob_size < {8'd0, minimum_blob_size};
`else
  logic filter_unused;
  assign filter_unused = ^{blob_size, minimum_blob_size};
  assign size_drop     = 1'b0;
`endif

  assign blob_extraction_blob_counter = cnt_q;
  assign blob_list_overflow           = ovf_q;
  assign blob_list_done               = (state_q == DONE);

  always_comb begin
    blob_ready = (state_q == WAIT_BLOB) && enable_blob_writer;
    wren       = 1'b0;
    address    = '0;
    data_write = '0;
    case (state_q)
      WR0:   begin wren = ~pause; address = entry_q;         data_write = w0_q;         end
      WR1:   begin wren = ~pause; address = entry_q + 18'd1; data_write = w1_q;         end
      WR2:   begin wren = ~pause; address = entry_q + 18'd2; data_write = w2_q;         end
      TERM0: begin wren = ~pause; address = entry_q;         data_write = 32'hFFFF_FFFF; end
      TERM1: begin wren = ~pause; address = entry_q + 18'd1; data_write = 32'hFFFF_FFFF; end
      TERM2: begin wren = ~pause; address = entry_q + 18'd2; data_write = 32'hFFFF_FFFF; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    dflag_d = dflag_q;
    entry_d = entry_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    if (extraction_done && state_q != IDLE && state_q != DONE) dflag_d = 1'b1;
    // Abort wins over everything; counter and overflow are deliberately kept.
    if (!enable_blob_writer && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (enable_blob_writer) begin
          state_d = WAIT_BLOB;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          dflag_d = 1'b0;
          entry_d = BASE;
        end
        WAIT_BLOB: if (blob_valid) begin
          w0_d = blob_word0;
          w1_d = blob_word1;
          w2_d = blob_word2;
          if (!size_drop) begin
            if (cnt_q >= CAP) ovf_d = 1'b1;
            else state_d = WR0;
          end
        end else if (dflag_q) begin
          state_d = TERM0;
        end
        WR0:   if (!pause) state_d = WR1;
        WR1:   if (!pause) state_d = WR2;
        WR2:   if (!pause) begin
          state_d = WAIT_BLOB;
          cnt_d   = cnt_q + 16'd1;
          entry_d = entry_q + 18'd3;
        end
        TERM0: if (!pause) state_d = TERM1;
        TERM1: if (!pause) state_d = TERM2;
        TERM2: if (!pause) state_d = DONE;
        DONE:  ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      dflag_q <= 1'b0;
      entry_q <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      dflag_q <= dflag_d;
      entry_q <= entry_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
    end
  end

endmodule
